// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// Pure declarations, no timing.
// No flow control; consumed by bp_table and branch_predictor.
package bp_pkg;

    localparam int BP_XLEN  = 32;
    localparam int BP_TAG_W = 8;

    // 2-bit direction counter: MSB set means predict taken
    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WEAK_NT;

    // Default-width view of one BTB entry
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
    } btb_entry_t;

    // Saturating step of a direction counter toward the resolved outcome
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        case (c)
            STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  n = taken ? STRONG_T : WEAK_T;
            default:   n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_table.sv
// BTB + direction counter storage: one combinational read port, one update port.
// Read is zero latency and returns pre-update contents; writes land at the clock edge.
// No backpressure; an update is accepted every cycle i_wr_en is high.
module bp_table
    import bp_pkg::*;
#(
    parameter int XLEN    = BP_XLEN,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = BP_TAG_W,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_rd_valid,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic [XLEN-1:0]  o_rd_target,
    output ctr_t             o_rd_ctr,
    input  logic             i_wr_en,
    input  logic             i_wr_inval,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic             i_wr_taken,
    input  logic [XLEN-1:0]  i_wr_target
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  target;
    } entry_t;

    entry_t r_entry [ENTRIES];
    ctr_t   r_ctr   [ENTRIES];
    logic   w_wr_hit;

    assign o_rd_valid  = r_entry[i_rd_idx].valid;
    assign o_rd_tag    = r_entry[i_rd_idx].tag;
    assign o_rd_target = r_entry[i_rd_idx].target;
    assign o_rd_ctr    = r_ctr[i_rd_idx];

    // The update side decides train-vs-allocate from the entry it is about to write
    assign w_wr_hit = r_entry[i_wr_idx].valid && (r_entry[i_wr_idx].tag == i_wr_tag);

    // Clear on reset; otherwise invalidate, train a hit, or allocate over a miss
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_entry[i] <= '0;
                r_ctr[i]   <= CTR_RESET;
            end
        end else if (i_wr_en) begin
            if (i_wr_inval) begin
                r_entry[i_wr_idx].valid <= 1'b0;
            end else if (w_wr_hit) begin
                r_ctr[i_wr_idx] <= ctr_next(r_ctr[i_wr_idx], i_wr_taken);
                if (i_wr_taken) begin
                    r_entry[i_wr_idx].target <= i_wr_target;
                end
            end else begin
                r_entry[i_wr_idx] <= '{valid: 1'b1, tag: i_wr_tag, target: i_wr_target};
                r_ctr[i_wr_idx]   <= i_wr_taken ? WEAK_T : WEAK_NT;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: IF lookup of next PC, EX resolve/redirect and training.
// Lookup and resolve are combinational (zero latency); training lands at the next edge.
// No backpressure; the pipeline presents one lookup and at most one resolve per cycle.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN    = BP_XLEN,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = BP_TAG_W,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  PCF,
    output logic             PredTakenF,
    output logic [XLEN-1:0]  NextPCF,
    output logic [XLEN-1:0]  PredTargetF,
    input  logic             ValidE,
    input  logic             BranchE,
    input  logic             TakenE,
    input  logic [XLEN-1:0]  PCE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic             PredTakenE,
    input  logic [XLEN-1:0]  PredTargetE,
    output logic             MispredictE,
    output logic [XLEN-1:0]  RedirectPCE,
    output logic [CNT_W-1:0] BranchCount,
    output logic [CNT_W-1:0] MispredCount
);

    localparam int              IDX_W   = $clog2(ENTRIES);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [IDX_W-1:0] w_idx_f;
    logic [TAG_W-1:0] w_tag_f;
    logic [IDX_W-1:0] w_idx_e;
    logic [TAG_W-1:0] w_tag_e;
    logic             w_rd_valid;
    logic [TAG_W-1:0] w_rd_tag;
    logic [XLEN-1:0]  w_rd_target;
    ctr_t             w_rd_ctr;
    logic             w_hit_f;
    logic             w_upd_en;
    logic [XLEN-1:0]  w_pcf_plus4;
    logic [XLEN-1:0]  w_pce_plus4;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    assign w_idx_f     = PCF[IDX_W+1:2];
    assign w_tag_f     = PCF[IDX_W+TAG_W+1:IDX_W+2];
    assign w_idx_e     = PCE[IDX_W+1:2];
    assign w_tag_e     = PCE[IDX_W+TAG_W+1:IDX_W+2];
    assign w_pcf_plus4 = PCF + PC_STEP;
    assign w_pce_plus4 = PCE + PC_STEP;

    // Table contents are stale during the reset cycle itself, so the hit is masked there
    assign w_hit_f     = ~reset & w_rd_valid & (w_rd_tag == w_tag_f);
    assign PredTakenF  = w_hit_f & ((w_rd_ctr == WEAK_T) || (w_rd_ctr == STRONG_T));
    assign NextPCF     = PredTakenF ? w_rd_target : w_pcf_plus4;
    assign PredTargetF = w_hit_f ? w_rd_target : '0;

    // Train on every resolved branch; a non-branch that was predicted taken invalidates the alias
    assign w_upd_en = ValidE & (BranchE | PredTakenE);

    bp_table #(
        .XLEN    (XLEN),
        .ENTRIES (ENTRIES),
        .TAG_W   (TAG_W),
        .IDX_W   (IDX_W)
    ) u_table (
        .clk         (clk),
        .reset       (reset),
        .i_rd_idx    (w_idx_f),
        .o_rd_valid  (w_rd_valid),
        .o_rd_tag    (w_rd_tag),
        .o_rd_target (w_rd_target),
        .o_rd_ctr    (w_rd_ctr),
        .i_wr_en     (w_upd_en),
        .i_wr_inval  (~BranchE),
        .i_wr_idx    (w_idx_e),
        .i_wr_tag    (w_tag_e),
        .i_wr_taken  (TakenE),
        .i_wr_target (PCTargetE)
    );

    // Resolve in EX: compare prediction to outcome and pick the correct continuation PC
    always_comb begin
        MispredictE = 1'b0;
        RedirectPCE = w_pce_plus4;
        if (ValidE) begin
            if (BranchE) begin
                MispredictE = (PredTakenE != TakenE) |
                              (TakenE & PredTakenE & (PredTargetE != PCTargetE));
                RedirectPCE = TakenE ? PCTargetE : w_pce_plus4;
            end else begin
                MispredictE = PredTakenE;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (ValidE && BranchE && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (MispredictE && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign BranchCount  = r_branch_cnt;
    assign MispredCount = r_mispred_cnt;

endmodule
